// File: rtl/ulpb_rx_fifo.sv
// ulpb_rx_fifo: receive-side message buffer behind the ULPB node RX port.
// Each received word is acknowledged with a 4-phase RX_REQ/RX_ACK handshake
// and written speculatively. A message becomes visible to the host only when
// its final word is accepted. Partial messages are rolled back on RX_FAIL or
// on lack of space, so the host never observes fragments.
module ulpb_rx_fifo #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  CLK_EXT,
    input  logic                  RESETn,
    input  logic [ADDR_WIDTH-1:0] RX_ADDR,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_PEND,
    input  logic                  RX_REQ,
    input  logic                  RX_FAIL,
    output logic                  RX_ACK,
    output logic [ADDR_WIDTH-1:0] HOST_ADDR,
    output logic [DATA_WIDTH-1:0] HOST_DATA,
    output logic                  HOST_LAST,
    output logic                  HOST_VALID,
    input  logic                  HOST_RD,
    output logic [PTR_WIDTH:0]    ENTRY_CNT,
    output logic                  OVERFLOW,
    input  logic                  OVF_CLR
);

    localparam int               ENTRY_W  = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] LP_DEPTH = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] LP_ONE   = {{PTR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK_WAIT = 2'd1,
        ST_DROP     = 2'd2,
        ST_DROP_ACK = 2'd3
    } state_t;

    // Synchronizer flops for the node-side asynchronous strobes
    logic r_req_meta;
    logic r_req_sync;
    logic r_fail_meta;
    logic r_fail_sync;
    logic r_fail_sync_d;

    // FSM, pointers and status registers
    state_t             r_state;
    logic [PTR_WIDTH:0] r_wr_ptr;
    logic [PTR_WIDTH:0] r_cm_ptr;
    logic [PTR_WIDTH:0] r_rd_ptr;
    logic               r_ack;
    logic               r_ovf;
    logic               r_host_valid;
    logic [PTR_WIDTH:0] r_entry_cnt;

    // Entry storage: {addr, data, last}
    logic [ENTRY_W-1:0] r_mem [DEPTH];

    // Combinational control
    logic               w_req_s;
    logic               w_fail_e;
    logic [PTR_WIDTH:0] w_spec_cnt;
    logic               w_full;
    logic               w_pop;
    state_t             w_state_base;
    state_t             w_state_nxt;
    logic               w_wr_en;
    logic [PTR_WIDTH:0] w_wr_ptr_nxt;
    logic [PTR_WIDTH:0] w_cm_ptr_nxt;
    logic [PTR_WIDTH:0] w_rd_ptr_nxt;
    logic               w_ack_nxt;
    logic               w_ovf_set;
    logic [ENTRY_W-1:0] w_head;

    assign w_req_s    = r_req_sync;
    assign w_fail_e   = r_fail_sync & ~r_fail_sync_d;
    assign w_spec_cnt = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_spec_cnt == LP_DEPTH);
    assign w_pop      = HOST_RD & r_host_valid;
    assign w_rd_ptr_nxt = r_rd_ptr + {{PTR_WIDTH{1'b0}}, w_pop};

    // Two-flop synchronizers for RX_REQ / RX_FAIL plus a delay flop for the fail edge
    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            r_req_meta    <= 1'b0;
            r_req_sync    <= 1'b0;
            r_fail_meta   <= 1'b0;
            r_fail_sync   <= 1'b0;
            r_fail_sync_d <= 1'b0;
        end else begin
            r_req_meta    <= RX_REQ;
            r_req_sync    <= r_req_meta;
            r_fail_meta   <= RX_FAIL;
            r_fail_sync   <= r_fail_meta;
            r_fail_sync_d <= r_fail_sync;
        end
    end

    // FSM state register
    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an abort pulls the drop states back to normal reception
    always_comb begin
        w_state_base = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_s) begin
                    if (w_full && RX_PEND) begin
                        w_state_base = ST_DROP_ACK;
                    end else begin
                        w_state_base = ST_ACK_WAIT;
                    end
                end else begin
                    w_state_base = ST_IDLE;
                end
            end
            ST_ACK_WAIT: begin
                if (!w_req_s) begin
                    w_state_base = ST_IDLE;
                end else begin
                    w_state_base = ST_ACK_WAIT;
                end
            end
            ST_DROP: begin
                if (w_req_s) begin
                    if (RX_PEND) begin
                        w_state_base = ST_DROP_ACK;
                    end else begin
                        w_state_base = ST_ACK_WAIT;
                    end
                end else begin
                    w_state_base = ST_DROP;
                end
            end
            ST_DROP_ACK: begin
                if (!w_req_s) begin
                    w_state_base = ST_DROP;
                end else begin
                    w_state_base = ST_DROP_ACK;
                end
            end
            default: begin
                w_state_base = ST_IDLE;
            end
        endcase

        w_state_nxt = w_state_base;
        if (w_fail_e) begin
            case (w_state_base)
                ST_DROP:     w_state_nxt = ST_IDLE;
                ST_DROP_ACK: w_state_nxt = ST_ACK_WAIT;
                default:     w_state_nxt = w_state_base;
            endcase
        end else begin
            w_state_nxt = w_state_base;
        end
    end

    // Per-state actions: store/drop the word, move pointers, drive the acknowledge
    always_comb begin
        w_wr_en      = 1'b0;
        w_wr_ptr_nxt = r_wr_ptr;
        w_cm_ptr_nxt = r_cm_ptr;
        w_ack_nxt    = r_ack;
        w_ovf_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_s) begin
                    w_ack_nxt = 1'b1;
                    if (!w_full) begin
                        if (!w_fail_e) begin
                            w_wr_en      = 1'b1;
                            w_wr_ptr_nxt = r_wr_ptr + LP_ONE;
                            if (!RX_PEND) begin
                                w_cm_ptr_nxt = r_wr_ptr + LP_ONE;
                            end else begin
                                w_cm_ptr_nxt = r_cm_ptr;
                            end
                        end else begin
                            w_wr_en = 1'b0;
                        end
                    end else begin
                        w_wr_ptr_nxt = r_cm_ptr;
                        w_ovf_set    = 1'b1;
                    end
                end else begin
                    w_ack_nxt = 1'b0;
                end
            end
            ST_ACK_WAIT: begin
                if (!w_req_s) begin
                    w_ack_nxt = 1'b0;
                end else begin
                    w_ack_nxt = 1'b1;
                end
            end
            ST_DROP: begin
                if (w_req_s) begin
                    w_ack_nxt = 1'b1;
                end else begin
                    w_ack_nxt = 1'b0;
                end
            end
            ST_DROP_ACK: begin
                if (!w_req_s) begin
                    w_ack_nxt = 1'b0;
                end else begin
                    w_ack_nxt = 1'b1;
                end
            end
            default: begin
                w_ack_nxt = 1'b0;
            end
        endcase

        // An abort discards every uncommitted word of the current message
        if (w_fail_e) begin
            w_wr_ptr_nxt = r_cm_ptr;
        end else begin
            w_wr_ptr_nxt = w_wr_ptr_nxt;
        end
    end

    // Pointer, acknowledge, overflow and host-status registers
    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            r_wr_ptr     <= {(PTR_WIDTH + 1){1'b0}};
            r_cm_ptr     <= {(PTR_WIDTH + 1){1'b0}};
            r_rd_ptr     <= {(PTR_WIDTH + 1){1'b0}};
            r_ack        <= 1'b0;
            r_ovf        <= 1'b0;
            r_host_valid <= 1'b0;
            r_entry_cnt  <= {(PTR_WIDTH + 1){1'b0}};
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_cm_ptr     <= w_cm_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_ack        <= w_ack_nxt;
            r_host_valid <= (w_cm_ptr_nxt != w_rd_ptr_nxt);
            r_entry_cnt  <= w_cm_ptr_nxt - w_rd_ptr_nxt;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (OVF_CLR) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    // Entry storage write port (contents need no reset; pointers gate visibility)
    always_ff @(posedge CLK_EXT) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[PTR_WIDTH-1:0]] <= {RX_ADDR, RX_DATA, ~RX_PEND};
        end
    end

    assign w_head     = r_mem[r_rd_ptr[PTR_WIDTH-1:0]];
    assign HOST_ADDR  = w_head[ENTRY_W-1 -: ADDR_WIDTH];
    assign HOST_DATA  = w_head[DATA_WIDTH:1];
    assign HOST_LAST  = w_head[0];
    assign HOST_VALID = r_host_valid;
    assign ENTRY_CNT  = r_entry_cnt;
    assign OVERFLOW   = r_ovf;
    assign RX_ACK     = r_ack;

endmodule
